// File: rtl/calc_result_uart_tx.sv
// Binary result -> decimal ASCII over 8N1 UART, terminated by CR LF.
// Optional macro CALC_TX_SIGNED_EN: treat result_i as two's complement and prefix '-'.
module calc_result_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tx_o
);

`ifdef CALC_TX_SIGNED_EN
    localparam int CW = WIDTH + 1;
`else
    localparam int CW = WIDTH;
`endif
    localparam int DIGITS = (CW <= 8) ? 3 : (CW <= 13) ? 4 : 5;
    localparam int BW     = 4 * DIGITS;
    localparam int CONV_W = $clog2(CW + 1);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);

    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CW - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        POS_CR    = 3'(DIGITS + 1);
    localparam logic [2:0]        POS_LF    = 3'(DIGITS + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD,
        S_SEND,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     sh_q, sh_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [CONV_W-1:0] conv_q, conv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [2:0]        pos_q, pos_d;
    logic [7:0]        byte_q, byte_d;
    logic              tx_q, tx_d;

    logic [CW-1:0]     mag;
    logic              neg_in;
    logic [BW-1:0]     bcd_adj;
    logic [2:0]        first_pos;
    logic [2:0]        start_pos;
    logic [2:0]        next_pos;

`ifdef CALC_TX_SIGNED_EN
    logic [CW-1:0] ext;
    always_comb begin
        ext    = {result_i[WIDTH-1], result_i};
        neg_in = result_i[WIDTH-1];
        mag    = neg_in ? -ext : ext;
    end
`else
    assign neg_in = 1'b0;
    assign mag    = result_i;
`endif

    // Byte positions: 0 = '-', 1..DIGITS = digits MS first, then CR, LF.
    function automatic logic [7:0] byte_at(input logic [2:0] p, input logic [BW-1:0] b);
        logic [7:0] r;
        r = 8'h0A;
        if (p == 3'd0) begin
            r = 8'h2D;
        end else if (p == POS_CR) begin
            r = 8'h0D;
        end else if (p == POS_LF) begin
            r = 8'h0A;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (p == 3'(DIGITS - k)) r = {4'h3, b[4*k +: 4]};
            end
        end
        return r;
    endfunction

    always_comb begin
        bcd_adj   = bcd_q;
        first_pos = 3'(DIGITS);
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            // Highest nonzero digit wins; all-zero falls back to the units digit.
            if (bcd_q[4*k +: 4] != 4'd0) first_pos = 3'(DIGITS - k);
        end
        start_pos = neg_q ? 3'd0 : first_pos;
        next_pos  = (pos_q == 3'd0) ? first_pos : pos_q + 3'd1;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        conv_d  = conv_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pos_d   = pos_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        ready_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE, S_FINISH: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                done_o  = (state_q == S_FINISH);
                state_d = S_IDLE;
                if (valid_i) begin
                    state_d = S_CONVERT;
                    sh_d    = mag;
                    neg_d   = neg_in;
                    bcd_d   = '0;
                    conv_d  = '0;
                end
            end
            S_CONVERT: begin
                bcd_d  = {bcd_adj[BW-2:0], sh_q[CW-1]};
                sh_d   = {sh_q[CW-2:0], 1'b0};
                conv_d = conv_q + 1'b1;
                if (conv_q == CONV_LAST) state_d = S_LOAD;
            end
            S_LOAD: begin
                pos_d   = start_pos;
                byte_d  = byte_at(start_pos, bcd_q);
                bit_d   = 4'd0;
                cnt_d   = '0;
                tx_d    = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : byte_q[bit_q[2:0]];
                    end else if (pos_q == POS_LF) begin
                        state_d = S_FINISH;
                        tx_d    = 1'b1;
                    end else begin
                        // Next byte chosen in the final stop cycle: no idle gap on the line.
                        pos_d  = next_pos;
                        byte_d = byte_at(next_pos, bcd_q);
                        bit_d  = 4'd0;
                        tx_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            conv_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            pos_q   <= 3'd0;
            byte_q  <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            conv_q  <= conv_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pos_q   <= pos_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: tb/tb_calc_result_uart_tx.sv
// Self-checking bench for calc_result_uart_tx: per-cycle waveform model, UART decoder scoreboard.
module tb_calc_result_uart_tx;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef CALC_TX_SIGNED_EN
    localparam int CW = WIDTH + 1;
`else
    localparam int CW = WIDTH;
`endif
    localparam int LAT = CW + 1;

    typedef logic [7:0] bytes_t [8];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] result_i = '0;
    logic             ready_o, busy_o, done_o, tx_o;

    calc_result_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .result_i (result_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .tx_o     (tx_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic cmp_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mb[$];
    logic [7:0] exp_q[$];
    logic       m_tx_q[$];
    int         m_phase = 0;   // 0 idle, 1 busy, 2 done pulse
    logic       m_tx = 1'b1;

    function automatic void build_bytes(input logic [WIDTH-1:0] v);
        int         mag;
        logic [7:0] ds[$];
        mb.delete();
        mag = int'(v);
`ifdef CALC_TX_SIGNED_EN
        if (v[WIDTH-1]) begin
            mb.push_back(8'h2D);
            mag = (1 << WIDTH) - mag;
        end
`endif
        if (mag == 0) ds.push_back(8'h30);
        while (mag > 0) begin
            ds.push_front(8'(48 + mag % 10));
            mag = mag / 10;
        end
        foreach (ds[i]) mb.push_back(ds[i]);
        mb.push_back(8'h0D);
        mb.push_back(8'h0A);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_tx    = 1'b1;
            m_tx_q.delete();
            exp_q.delete();
        end else if (m_phase != 1 && valid_i) begin
            build_bytes(result_i);
            m_tx_q.delete();
            repeat (LAT) m_tx_q.push_back(1'b1);
            foreach (mb[i]) begin
                exp_q.push_back(mb[i]);
                repeat (CPB) m_tx_q.push_back(1'b0);
                for (int b = 0; b < 8; b++) repeat (CPB) m_tx_q.push_back(mb[i][b]);
                repeat (CPB) m_tx_q.push_back(1'b1);
            end
            m_tx    = m_tx_q.pop_front();
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_tx_q.size() > 0) begin
                m_tx = m_tx_q.pop_front();
            end else begin
                m_phase = 2;
                m_tx    = 1'b1;
            end
        end else begin
            m_phase = 0;
            m_tx    = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready_o", ready_o, m_phase != 1);
            check("busy_o",  busy_o,  m_phase == 1);
            check("done_o",  done_o,  m_phase == 2);
            check("tx_o",    tx_o,    (m_phase == 1) ? m_tx : 1'b1);
        end
    end

    // ---------------- line decoder / scoreboard ----------------
    logic [7:0] rx_log[$];

    initial begin
        logic [7:0] b;
        logic       aborted;
        logic       stop_bit;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0 && !rst) begin
                aborted  = 1'b0;
                b        = 8'd0;
                stop_bit = 1'b0;
                for (int k = 1; k <= 9; k++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (rst) aborted = 1'b1;
                    end
                    if (k <= 8) b[k-1] = tx_o;
                    else stop_bit = tx_o;
                end
                if (!aborted) begin
                    check("stop_bit", stop_bit, 1'b1);
                    rx_log.push_back(b);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_extra: got byte %h required none", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (ready_o !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_ready", ready_o, 1'b1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy_o !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idle", busy_o, 1'b0);
    endtask

    task automatic check_model(input logic [WIDTH-1:0] v, input bytes_t e, input int n);
        build_bytes(v);
        check("model_len", mb.size(), n);
        for (int i = 0; i < n; i++) check("model_byte", mb[i], e[i]);
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] v, input bytes_t e,
                            input int n, input int busy_len);
        int t_acc, t_fall, t_end, guard, dones;
        wait_ready();
        rx_log.delete();
        valid_i  = 1'b1;
        result_i = v;
        @(negedge clk);
        valid_i = 1'b0;
        t_acc  = cyc;
        t_fall = -1;
        dones  = 0;
        guard  = 0;
        while (busy_o === 1'b1 && guard < 5000) begin
            if (t_fall < 0 && tx_o === 1'b0) t_fall = cyc;
            @(negedge clk);
            guard++;
        end
        t_end = cyc;
        if (done_o === 1'b1) dones++;
        @(negedge clk);
        if (done_o === 1'b1) dones++;
        check({name, "_latency"}, t_fall - t_acc, LAT);
        check({name, "_busy_len"}, t_end - t_acc, busy_len);
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_rx_len"}, rx_log.size(), n);
        for (int i = 0; i < n && i < rx_log.size(); i++) check({name, "_rx"}, rx_log[i], e[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] v;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifdef CALC_TX_SIGNED_EN
        check_model(8'h85, '{8'h2D, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 8'h00}, 6);
        check_model(8'h80, '{8'h2D, 8'h31, 8'h32, 8'h38, 8'h0D, 8'h0A, 8'h00, 8'h00}, 6);
        check_model(8'h7F, '{8'h31, 8'h32, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5);
        check_model(8'h00, '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        directed("s85", 8'h85, '{8'h2D, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 8'h00}, 6, LAT + 60 * CPB);
        directed("s80", 8'h80, '{8'h2D, 8'h31, 8'h32, 8'h38, 8'h0D, 8'h0A, 8'h00, 8'h00}, 6, LAT + 60 * CPB);
        directed("s7f", 8'h7F, '{8'h31, 8'h32, 8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5, LAT + 50 * CPB);
        directed("s00", 8'h00, '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, LAT + 30 * CPB);
`else
        check_model(8'd123, '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5);
        check_model(8'd0,   '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        check_model(8'd7,   '{8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        check_model(8'd255, '{8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5);
        directed("d123", 8'd123, '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5, 9 + 200);
        directed("d0",   8'd0,   '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 9 + 120);
        directed("d7",   8'd7,   '{8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 9 + 120);
        directed("d255", 8'd255, '{8'h32, 8'h35, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5, 9 + 200);
`endif

        // valid held high with result changing every cycle
        wait_ready();
        for (int i = 0; i < 2 * (LAT + 60 * CPB) + 20; i++) begin
            valid_i  = 1'b1;
            result_i = WIDTH'($urandom);
            @(negedge clk);
        end
        valid_i = 1'b0;
        wait_idle();

        // reset during data bits of the second byte
        wait_ready();
        valid_i  = 1'b1;
        result_i = 8'd123;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (LAT - 1 + 10 * CPB + 3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", tx_o, 1'b1);
        check("rst_ready", ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        directed("after_rst", 8'd123, '{8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 5,
                 LAT + 50 * CPB);

        // randomized requests, some arriving while busy
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            case ($urandom_range(0, 7))
                0: v = '0;
                1: v = '1;
                2: v = {1'b1, {(WIDTH-1){1'b0}}};
                default: v = WIDTH'($urandom);
            endcase
            valid_i  = 1'b1;
            result_i = v;
            @(negedge clk);
            valid_i = 1'b0;
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_result_uart_tx.md
Name: calc_result_uart_tx

Overview:
Output-side companion to the calculator core. It takes a finished binary result, converts it to decimal with a sequential double-dabble, and serialises the digits as ASCII over an 8N1 UART line, terminated by CR LF. It sits between the calculator datapath result register and a dedicated output pin.

Parameters:
WIDTH, 8, bit width of result_i; legal values 4..16.
CLKS_PER_BIT, 104, clock cycles per UART bit; must be >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
result_i  input  WIDTH  result value to transmit; sampled only on accept.
valid_i  input  1  request to send result_i.
ready_o  output  1  high when idle and able to accept.
busy_o  output  1  high from the accept edge until the last stop bit ends.
done_o  output  1  one-cycle pulse after the final LF stop bit.
tx_o  output  1  UART line, idle high.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high.
- Reset values: tx_o=1, ready_o=1, busy_o=0, done_o=0, state=IDLE, all counters 0.
- rst asserted mid-frame: the next edge forces the reset values. tx_o is high one cycle later, with no partial-byte completion.
- Accept: on the edge where valid_i=1 and ready_o=1. result_i is latched and ready_o drops on that edge. valid_i while busy is ignored; there is no queueing.
- DIGITS = 3 for WIDTH<=8, 4 for WIDTH<=13, 5 for WIDTH<=16 (localparam).
- FSM states: IDLE -> CONVERT -> LOAD -> SEND -> (LOAD | FINISH) -> IDLE.
- CONVERT runs for exactly WIDTH cycles of shift-add-3 double dabble into a 4*DIGITS-bit BCD register.
- LOAD selects the next byte:
  - the digit sequence is sent most significant first;
  - leading zeros are suppressed, but a value of 0 sends a single '0' (0x30);
  - each digit byte is 0x30 + digit;
  - after the last digit, 0x0D then 0x0A are sent.
- SEND transmits one frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Bytes are back-to-back: the next start bit follows the previous stop bit with no idle gap. The LOAD decision is taken in the last cycle of the stop bit, so it costs zero line cycles.
- Latency: tx_o falls exactly WIDTH+1 cycles after the accept edge.
- FINISH: done_o pulses for one cycle, busy_o falls and ready_o rises on the same edge. A new accept is possible on the following edge.
- Total line time: (n_digits + 2) * 10 * CLKS_PER_BIT cycles.

Optional Feature:
Macro CALC_TX_SIGNED_EN.
- Defined: result_i is two's complement. If the MSB is set, '-' (0x2D) is sent first and the magnitude is converted. Conversion uses WIDTH+1 bits so that the most negative value converts correctly; the latency becomes WIDTH+2, and DIGITS is computed from WIDTH+1.
- Undefined: result_i is unsigned, no '-' is ever emitted, and latency is as stated above.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=4, result_i=123 with valid_i pulsed -> line decodes 0x31 0x32 0x33 0x0D 0x0A; first falling edge of tx_o 9 cycles after accept; done_o pulses once; busy_o high for 9+200 cycles.
- result_i=0 -> 0x30 0x0D 0x0A. result_i=7 -> 0x37 0x0D 0x0A (no leading zeros). result_i=255 -> 0x32 0x35 0x35 0x0D 0x0A.
- valid_i held high continuously with result_i changing every cycle -> only the value on the first accept edge is sent. The next accept occurs exactly one edge after done_o, and the two frames are separated by a single ready cycle.
- rst asserted during the data bits of the second byte -> tx_o=1, ready_o=1, busy_o=0 on the following cycle. No further edges on tx_o. A new valid_i then transmits a full, correct sequence.
- CALC_TX_SIGNED_EN defined, WIDTH=8: 0x85 -> 0x2D 0x31 0x32 0x33 0x0D 0x0A; 0x80 -> 0x2D 0x31 0x32 0x38 0x0D 0x0A; 0x7F -> 0x31 0x32 0x37 0x0D 0x0A.
- WIDTH=16, CLKS_PER_BIT=2, result_i=65535 -> 0x36 0x35 0x35 0x33 0x35 0x0D 0x0A; tx_o falls 17 cycles after accept.
